// File: rtl/l1_request_arbiter.sv
// l1_request_arbiter
//   Shares the single L1-to-memory request port among four requesters
//   (DCACHE=0, DMMU=1, ICACHE=2, IMMU=3). It grants one request per free
//   output slot, registers it toward memory, and tracks outstanding reads so
//   that in-order read data can be routed back to the requester that issued it.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_*             per-requester request (valid/ready handshake)
//   mem_*             registered request toward memory (valid/ready handshake)
//   mem_rd_valid/data read data words from memory, in issue order
//   rd_valid/rd_data  per-requester read data strobe (one-hot), broadcast data
//   protocol_error    pulses when read data arrives with no outstanding read
module l1_request_arbiter #(
  parameter int L1_CONNECTIONS  = 4,
  parameter int DATA_W          = 32,
  parameter int MAX_BURST_W     = 5,
  parameter int READ_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT    = 15
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [L1_CONNECTIONS-1:0]                     req_valid,
  output logic [L1_CONNECTIONS-1:0]                     req_ready,
  input  logic [L1_CONNECTIONS-1:0][31:0]               req_addr,
  input  logic [L1_CONNECTIONS-1:0]                     req_rnw,
  input  logic [L1_CONNECTIONS-1:0][DATA_W/8-1:0]       req_be,
  input  logic [L1_CONNECTIONS-1:0][DATA_W-1:0]         req_data,
  input  logic [L1_CONNECTIONS-1:0][MAX_BURST_W-1:0]    req_size,
  output logic                                          mem_valid,
  input  logic                                          mem_ready,
  output logic [31:0]                                   mem_addr,
  output logic                                          mem_rnw,
  output logic [DATA_W/8-1:0]                           mem_be,
  output logic [DATA_W-1:0]                             mem_data,
  output logic [MAX_BURST_W-1:0]                        mem_size,
  output logic [$clog2(L1_CONNECTIONS)-1:0]             mem_id,
  input  logic                                          mem_rd_valid,
  input  logic [DATA_W-1:0]                             mem_rd_data,
  output logic [L1_CONNECTIONS-1:0]                     rd_valid,
  output logic [DATA_W-1:0]                             rd_data,
  output logic                                          protocol_error
);

  localparam int ID_W     = $clog2(L1_CONNECTIONS);
  localparam int PTR_W    = $clog2(READ_FIFO_DEPTH);
  localparam int CNT_W    = $clog2(READ_FIFO_DEPTH + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  // Output request register
  logic                   mem_valid_reg;
  logic [31:0]            mem_addr_reg;
  logic                   mem_rnw_reg;
  logic [DATA_W/8-1:0]    mem_be_reg;
  logic [DATA_W-1:0]      mem_data_reg;
  logic [MAX_BURST_W-1:0] mem_size_reg;
  logic [ID_W-1:0]        mem_id_reg;

  // Outstanding-read FIFO of {id, size}
  logic [ID_W-1:0]        fifo_id_mem   [READ_FIFO_DEPTH];
  logic [MAX_BURST_W-1:0] fifo_size_mem [READ_FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_reg;
  logic [PTR_W-1:0]       rd_ptr_reg;
  logic [CNT_W-1:0]       fifo_count_reg;
  logic [MAX_BURST_W-1:0] beat_reg;

  logic [STARVE_W-1:0]    starve_cnt_reg [L1_CONNECTIONS];

  logic                      out_free;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [L1_CONNECTIONS-1:0] eligible;
  logic [L1_CONNECTIONS-1:0] starved;
  logic [L1_CONNECTIONS-1:0] grant;
  logic                      grant_valid;
  logic [ID_W-1:0]           win_id;
  logic                      push;
  logic                      pop;
  logic                      rd_hit;
  logic [ID_W-1:0]           head_id;
  logic [MAX_BURST_W-1:0]    head_size;

  assign out_free   = !mem_valid_reg || mem_ready;
  // Full is judged on the registered count; a pop in the same cycle does not
  // open a slot until the next cycle.
  assign fifo_full  = (fifo_count_reg == CNT_W'(READ_FIFO_DEPTH));
  assign fifo_empty = (fifo_count_reg == '0);

  // Per-requester eligibility and starvation tracking
  generate
    for (genvar gi = 0; gi < L1_CONNECTIONS; gi++) begin : g_req
      assign eligible[gi] = req_valid[gi] && (!req_rnw[gi] || !fifo_full);
      assign starved[gi]  = eligible[gi] && (starve_cnt_reg[gi] >= STARVE_W'(STARVE_LIMIT));

      always_ff @(posedge clk) begin
        if (rst) begin
          starve_cnt_reg[gi] <= '0;
        end else if (!req_valid[gi] || grant[gi]) begin
          starve_cnt_reg[gi] <= '0;
        end else if (starve_cnt_reg[gi] != STARVE_W'(STARVE_LIMIT)) begin
          starve_cnt_reg[gi] <= starve_cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  // Starved requesters outrank everyone; otherwise lowest ID wins.
  always_comb begin
    logic found;
    found  = 1'b0;
    win_id = '0;
    for (int i = 0; i < L1_CONNECTIONS; i++) begin
      if (starved[i] && !found) begin
        found  = 1'b1;
        win_id = ID_W'(i);
      end
    end
    for (int i = 0; i < L1_CONNECTIONS; i++) begin
      if (eligible[i] && !found) begin
        found  = 1'b1;
        win_id = ID_W'(i);
      end
    end
    grant_valid = found && out_free && !rst;
    grant       = grant_valid ? (L1_CONNECTIONS'(1) << win_id) : '0;
  end

  assign req_ready = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid_reg <= 1'b0;
    end else if (out_free) begin
      mem_valid_reg <= grant_valid;
      if (grant_valid) begin
        mem_addr_reg <= req_addr[win_id];
        mem_rnw_reg  <= req_rnw[win_id];
        mem_be_reg   <= req_be[win_id];
        mem_data_reg <= req_data[win_id];
        mem_size_reg <= req_size[win_id];
        mem_id_reg   <= win_id;
      end
    end
  end

  assign mem_valid = mem_valid_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_rnw   = mem_rnw_reg;
  assign mem_be    = mem_be_reg;
  assign mem_data  = mem_data_reg;
  assign mem_size  = mem_size_reg;
  assign mem_id    = mem_id_reg;

  // Read tracking: push on read capture, pop on the last beat of the head.
  assign push      = grant_valid && req_rnw[win_id];
  assign head_id   = fifo_id_mem[rd_ptr_reg];
  assign head_size = fifo_size_mem[rd_ptr_reg];
  assign rd_hit    = mem_rd_valid && !fifo_empty && !rst;
  assign pop       = rd_hit && (beat_reg == head_size);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id_mem[wr_ptr_reg]   <= win_id;
      fifo_size_mem[wr_ptr_reg] <= req_size[win_id];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
      beat_reg       <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      fifo_count_reg <= fifo_count_reg + 1'b1;
      else if (pop && !push) fifo_count_reg <= fifo_count_reg - 1'b1;
      if (pop)         beat_reg <= '0;
      else if (rd_hit) beat_reg <= beat_reg + 1'b1;
    end
  end

  // Read data is passed straight through in the cycle it arrives.
  assign rd_valid       = rd_hit ? (L1_CONNECTIONS'(1) << head_id) : '0;
  assign rd_data        = mem_rd_data;
  assign protocol_error = mem_rd_valid && fifo_empty && !rst;

endmodule

// File: tb/tb_l1_request_arbiter.sv
// Testbench for l1_request_arbiter: table-driven arbitration vectors plus
// hand-written sequences for starvation, stall, FIFO-full and read routing.
// Memory requests and read responses are checked through scoreboard queues.
module tb_l1_request_arbiter;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [3:0]        req_valid = '0;
  logic [3:0]        req_ready;
  logic [3:0][31:0]  req_addr = '0;
  logic [3:0]        req_rnw = '0;
  logic [3:0][3:0]   req_be = '0;
  logic [3:0][31:0]  req_data = '0;
  logic [3:0][4:0]   req_size = '0;
  logic              mem_valid;
  logic              mem_ready = 1'b0;
  logic [31:0]       mem_addr;
  logic              mem_rnw;
  logic [3:0]        mem_be;
  logic [31:0]       mem_data;
  logic [4:0]        mem_size;
  logic [1:0]        mem_id;
  logic              mem_rd_valid = 1'b0;
  logic [31:0]       mem_rd_data = '0;
  logic [3:0]        rd_valid;
  logic [31:0]       rd_data;
  logic              protocol_error;

  always #5 clk = ~clk;

  l1_request_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rnw(req_rnw), .req_be(req_be), .req_data(req_data), .req_size(req_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_rnw(mem_rnw), .mem_be(mem_be), .mem_data(mem_data), .mem_size(mem_size),
    .mem_id(mem_id), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .protocol_error(protocol_error)
  );

  typedef struct {
    logic [1:0]  id;
    logic [31:0] addr;
    logic        rnw;
    logic [3:0]  be;
    logic [31:0] data;
    logic [4:0]  size;
  } mem_exp_t;

  typedef struct {
    logic [3:0]  rdv;
    logic [31:0] data;
    logic        perr;
  } rd_exp_t;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] rnw;
    logic [3:0] exp_ready;
  } vec_t;

  mem_exp_t mem_q[$];
  rd_exp_t  rd_q[$];
  mem_exp_t mon_m;
  rd_exp_t  mon_r;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rnw, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be, input logic [4:0] size);
    req_rnw[i]  = rnw;
    req_addr[i] = addr;
    req_data[i] = data;
    req_be[i]   = be;
    req_size[i] = size;
  endtask

  task automatic push_mem(input int i);
    mem_q.push_back('{id: 2'(i), addr: req_addr[i], rnw: req_rnw[i], be: req_be[i],
                      data: req_data[i], size: req_size[i]});
  endtask

  task automatic drive_beat(input logic [3:0] exp_rdv, input logic exp_perr);
    mem_rd_valid = 1'b1;
    mem_rd_data  = $urandom;
    rd_q.push_back('{rdv: exp_rdv, data: mem_rd_data, perr: exp_perr});
  endtask

  task automatic do_reset();
    req_valid    = '0;
    mem_rd_valid = 1'b0;
    mem_ready    = 1'b1;
    tick();
    chk("sb_mem_drained", 64'(mem_q.size()), 64'd0);
    chk("sb_rd_drained", 64'(rd_q.size()), 64'd0);
    rst = 1'b1;
    mem_q.delete();
    rd_q.delete();
    req_valid = 4'hf;
    tick();
    @(negedge clk);
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_perr", 64'(protocol_error), 64'd0);
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: memory requests on acceptance, read data per beat.
  always @(negedge clk) begin
    if (!rst && mem_valid && mem_ready) begin
      if (mem_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mem_unexpected actual id=%0d addr=%h expected no request", mem_id, mem_addr);
      end else begin
        mon_m = mem_q.pop_front();
        chk("mem_id", 64'(mem_id), 64'(mon_m.id));
        chk("mem_addr", 64'(mem_addr), 64'(mon_m.addr));
        chk("mem_rnw", 64'(mem_rnw), 64'(mon_m.rnw));
        chk("mem_be", 64'(mem_be), 64'(mon_m.be));
        chk("mem_data", 64'(mem_data), 64'(mon_m.data));
        chk("mem_size", 64'(mem_size), 64'(mon_m.size));
      end
    end
    if (!rst) begin
      if (mem_rd_valid) begin
        if (rd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected actual rd_valid=%b expected no beat", rd_valid);
        end else begin
          mon_r = rd_q.pop_front();
          chk("rd_valid", 64'(rd_valid), 64'(mon_r.rdv));
          chk("rd_perr", 64'(protocol_error), 64'(mon_r.perr));
          if (mon_r.rdv != 4'b0000) chk("rd_data", 64'(rd_data), 64'(mon_r.data));
        end
      end else begin
        chk("rd_idle_valid", 64'(rd_valid), 64'd0);
        chk("rd_idle_perr", 64'(protocol_error), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vec_t vecs[8];
    int   ids[$];
    int   h;
    int   w;

    vecs[0] = '{valid: 4'b0001, rnw: 4'b1111, exp_ready: 4'b0001};
    vecs[1] = '{valid: 4'b1110, rnw: 4'b1111, exp_ready: 4'b0010};
    vecs[2] = '{valid: 4'b1100, rnw: 4'b0000, exp_ready: 4'b0100};
    vecs[3] = '{valid: 4'b1000, rnw: 4'b1000, exp_ready: 4'b1000};
    vecs[4] = '{valid: 4'b0000, rnw: 4'b1111, exp_ready: 4'b0000};
    vecs[5] = '{valid: 4'b1010, rnw: 4'b0010, exp_ready: 4'b0010};
    vecs[6] = '{valid: 4'b1111, rnw: 4'b0101, exp_ready: 4'b0001};
    vecs[7] = '{valid: 4'b0110, rnw: 4'b0100, exp_ready: 4'b0010};

    // Table-driven single-cycle arbitration from a clean state
    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int i = 0; i < 4; i++)
        set_req(i, vecs[v].rnw[i], 32'h1000_0000 + 32'(i) * 32'h100 + 32'(v) * 4,
                $urandom, 4'(i + 1), vecs[v].rnw[i] ? 5'(v) : 5'd0);
      req_valid = vecs[v].valid;
      @(negedge clk);
      chk("tbl_ready", 64'(req_ready), 64'(vecs[v].exp_ready));
      for (int i = 0; i < 4; i++)
        if (vecs[v].exp_ready[i]) push_mem(i);
      tick();
      req_valid = '0;
    end

    // All four read at once: grants in ID order, one per cycle
    do_reset();
    for (int i = 0; i < 4; i++)
      set_req(i, 1'b1, 32'h2000_0000 + 32'(i) * 4, '0, 4'hf, 5'd0);
    req_valid = 4'hf;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_order_ready", 64'(req_ready), 64'(4'b0001 << k));
      push_mem(k);
      tick();
      req_valid[k] = 1'b0;
      if (k > 0) chk("rr_mem_valid", 64'(mem_valid), 64'd1);
    end

    // Starvation: DCACHE streams reads, IMMU waits 15 cycles then wins
    do_reset();
    set_req(0, 1'b1, 32'h3000_0000, '0, 4'hf, 5'd0);
    set_req(3, 1'b1, 32'h3000_0300, '0, 4'hf, 5'd0);
    req_valid = 4'b1001;
    for (int c = 0; c < 17; c++) begin
      if (c > 0) begin
        h = ids.pop_front();
        drive_beat(4'b0001 << h, 1'b0);
      end
      w = (c == 15) ? 3 : 0;
      @(negedge clk);
      chk("starve_ready", 64'(req_ready), 64'(4'b0001 << w));
      push_mem(w);
      ids.push_back(w);
      tick();
      if (w == 3) req_valid[3] = 1'b0;
    end
    req_valid = '0;
    h = ids.pop_front();
    drive_beat(4'b0001 << h, 1'b0);
    tick();
    mem_rd_valid = 1'b0;

    // Memory stall: captured write held stable, no further grants
    do_reset();
    mem_ready = 1'b0;
    set_req(1, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hf, 5'd0);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("stall_first_ready", 64'(req_ready), 64'b0010);
    push_mem(1);
    tick();
    req_valid = 4'b0001;
    set_req(1, 1'b1, 32'h0, 32'h0, 4'h0, 5'd7);
    set_req(0, 1'b0, 32'h4000_0000, 32'h1234_5678, 4'h3, 5'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_ready", 64'(req_ready), 64'd0);
      chk("stall_valid", 64'(mem_valid), 64'd1);
      chk("stall_addr", 64'(mem_addr), 64'h8000_0010);
      chk("stall_data", 64'(mem_data), 64'hDEAD_BEEF);
      chk("stall_id", 64'(mem_id), 64'd1);
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_ready", 64'(req_ready), 64'b0001);
    push_mem(0);
    tick();
    req_valid = '0;

    // FIFO full: reads blocked, writes pass, read resumes after first pop
    do_reset();
    set_req(2, 1'b1, 32'h5000_0000, '0, 4'hf, 5'd3);
    req_valid = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("fill_ready", 64'(req_ready), 64'b0100);
      push_mem(2);
      tick();
      req_addr[2] = req_addr[2] + 32'h10;
    end
    set_req(0, 1'b0, 32'h5000_1000, 32'hCAFE_F00D, 4'h6, 5'd0);
    req_valid[0] = 1'b1;
    @(negedge clk);
    chk("full_write_ready", 64'(req_ready), 64'b0001);
    push_mem(0);
    tick();
    req_valid[0] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      drive_beat(4'b0100, 1'b0);
      @(negedge clk);
      chk("full_block_ready", 64'(req_ready), 64'd0);
      tick();
    end
    mem_rd_valid = 1'b0;
    @(negedge clk);
    chk("unblock_ready", 64'(req_ready), 64'b0100);
    push_mem(2);
    tick();
    req_valid = '0;

    // Routing: DMMU 1 beat, ICACHE 4 beats, then a stray beat
    do_reset();
    set_req(1, 1'b1, 32'h6000_0000, '0, 4'hf, 5'd0);
    set_req(2, 1'b1, 32'h6000_0100, '0, 4'hf, 5'd3);
    req_valid = 4'b0110;
    @(negedge clk);
    chk("route_grant_dmmu", 64'(req_ready), 64'b0010);
    push_mem(1);
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("route_grant_icache", 64'(req_ready), 64'b0100);
    push_mem(2);
    tick();
    req_valid = '0;
    tick();
    for (int b = 0; b < 5; b++) begin
      drive_beat((b == 0) ? 4'b0010 : 4'b0100, 1'b0);
      tick();
    end
    drive_beat(4'b0000, 1'b1);
    tick();
    mem_rd_valid = 1'b0;
    tick();

    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l1_request_arbiter.md
Name: l1_request_arbiter

Overview:
- Shares the single L1-to-memory request port among the four L1 requesters: DCACHE=0, DMMU=1, ICACHE=2, IMMU=3 (l1_id_t order).
- Registers one granted request toward memory and records each outstanding read's requester and burst length.
- Routes in-order read data back to the requester that issued the read.
- Sits between the caches/MMUs and the external memory interface.

Parameters:
- L1_CONNECTIONS, 4, number of requesters (fixed-width 2-bit ID).
- DATA_W, 32, data width in bits.
- MAX_BURST_W, 5, burst length field width; a read transfers size+1 words, max 32.
- READ_FIFO_DEPTH, 4, number of outstanding reads tracked (power of 2).
- STARVE_LIMIT, 15, wait cycles before a requester is promoted to top priority.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  4  per-requester request valid
- req_ready  out  4  per-requester accept; one-hot or zero
- req_addr  in  4x32  word-aligned byte address per requester
- req_rnw  in  4  1=read, 0=write
- req_be  in  4x4  byte enables (writes)
- req_data  in  4x32  write data
- req_size  in  4x5  burst length minus 1 (reads); must be 0 for writes
- mem_valid  out  1  request to memory valid
- mem_ready  in  1  memory accepts request
- mem_addr  out  32  registered address
- mem_rnw  out  1  registered read/write
- mem_be  out  4  registered byte enables
- mem_data  out  32  registered write data
- mem_size  out  5  registered burst length minus 1
- mem_id  out  2  registered requester ID
- mem_rd_valid  in  1  read data word valid (in issue order)
- mem_rd_data  in  32  read data word
- rd_valid  out  4  per-requester read data valid, one-hot
- rd_data  out  32  read data, broadcast
- protocol_error  out  1  one-cycle pulse on read data with no outstanding read

Behaviour:
- Reset values: mem_valid=0, req_ready=0, rd_valid=0, protocol_error=0; read FIFO empty; beat counter=0; starvation counters=0. Reset mid-transaction discards all outstanding state with no drain.
- Output register free when mem_valid=0 or (mem_valid & mem_ready).
- Arbitration runs combinationally each cycle the register is free.
  - Eligible requester: req_valid=1, and either a write, or the read FIFO is not full (count<READ_FIFO_DEPTH, ignoring a same-cycle pop).
  - Priority: any eligible requester whose starvation counter ≥ STARVE_LIMIT wins first, lowest ID among those; otherwise fixed priority 0>1>2>3.
- Grant: req_ready[w]=1 for the winner only; the request is captured into the mem_* registers next edge and mem_valid=1 the next cycle. Latency from req_valid to mem_valid is 1 cycle.
- mem_* fields are held stable while mem_valid & !mem_ready.
- Starvation counter per requester:
  - Increments (saturating at STARVE_LIMIT) each cycle req_valid=1 and not granted.
  - Clears on grant or when req_valid=0.
- Read FIFO:
  - Push {id,size} when a read is captured into the output register.
  - Full blocks read grants only; writes continue.
- Response routing:
  - On mem_rd_valid with FIFO non-empty: rd_valid[head.id]=1 and rd_data=mem_rd_data in the same cycle (combinational pass-through); beat counter increments.
  - When beat counter == head.size: pop the FIFO and clear the beat counter.
  - Simultaneous push and pop in one cycle is allowed; count is unchanged.
  - mem_rd_valid with FIFO empty: data dropped, protocol_error=1 for that cycle.
- Write request with req_size≠0: forwarded unchanged; the arbiter does not check it.

Test Plan:
- Reset, then all four requesters assert reads with size=0, mem_ready=1 → grants in cycle order 0,1,2,3; mem_id sequence 0,1,2,3 on consecutive cycles; each grant lasts one cycle.
- DCACHE issues back-to-back reads continuously while IMMU holds a read → IMMU is granted on the cycle after its counter reaches 15 (16th waiting cycle), then DCACHE resumes.
- mem_ready=0 for 5 cycles with a pending write addr=0x80000010, data=0xDEADBEEF → mem_* fields stable across all 5 cycles; req_ready all 0 until accepted.
- Four ICACHE reads of size=3 queued (FIFO full), then a DCACHE write → write is granted; a fifth read is blocked until 4 data beats return and the first entry pops.
- DMMU read size=0 then ICACHE read size=3; 5 data beats returned → rd_valid[1] on beat 1, rd_valid[2] on beats 2–5, FIFO empty afterwards.
- mem_rd_valid pulsed with no outstanding read → protocol_error=1 for one cycle; rd_valid stays 0.
